encodeur_8vers3_sync: RTL
=========================

Name: encodeur_8vers3_sync

Overview:
- Sequential inverse of the team's 3-to-8 active-low decoder.
- Takes eight active-low one-hot request lines (keypad/selector lines, or the decoder's own output looped back for self-test) and synchronises and debounces them.
- Priority-encodes the lowest active line to a 3-bit code and hands it to the consumer through a Valid/Ack handshake.
- Each press is reported exactly once: no re-report until all lines go inactive.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive identical synchronised samples required before a new line state is accepted. Legal range is 2..255; elaboration fails outside it.

Ports:
- Clk  input  1  single rising-edge clock
- nReset  input  1  asynchronous, active-low reset
- DecodedInput  input  8  request lines, active level 0, asynchronous to Clk
- CodedOutput  output  3  index of the lowest-numbered active line; registered
- Valid  output  1  CodedOutput/Multiple hold a new, unacknowledged report
- Ack  input  1  consumer accepts the report; sampled only while Valid=1
- Multiple  output  1  more than one line was active when the report was captured

Behaviour:
- Reset (nReset=0, asynchronous assert, synchronous release by design of the reset tree):
  - Synchroniser stages and debounced state = 8'hFF (all inactive).
  - Debounce counter = 0; FSM = IDLE.
  - CodedOutput = 3'd0, Valid = 0, Multiple = 0.
- Synchroniser:
  - Two flops on DecodedInput; the second-stage value is S.
- Debouncer:
  - Counter clears whenever S differs from its previous-cycle value; otherwise it increments, saturating.
  - When S has been unchanged for DEBOUNCE_CYCLES consecutive edges, D <= S.
  - Glitches shorter than DEBOUNCE_CYCLES never reach D.
- Encoding (combinational on D):
  - Code = lowest index i with D[i]=0.
  - Many = count of zeros in D > 1.
- FSM:
  - IDLE: Valid=0. If D != 8'hFF, then on the next edge: CodedOutput <= code, Multiple <= Many, Valid <= 1, go to HOLD.
  - HOLD: Valid=1; CodedOutput and Multiple frozen and unaffected by D changes. On an edge with Ack=1: Valid <= 0, go to RELEASE.
  - RELEASE: Valid=0; wait for D == 8'hFF, then go to IDLE. A line still held is never re-reported.
  - CodedOutput and Multiple keep their last values outside HOLD.
- Latency:
  - A clean input change held stable raises Valid exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples it (7 for the default).
  - Ack to Valid low: 1 edge.
- Boundary conditions:
  - Ack while Valid=0: ignored, with no effect on state.
  - Ack held high continuously: each report lasts exactly one cycle of Valid.
  - Lines release and re-press during HOLD: ignored. After Ack, the FSM passes through RELEASE only if D returns to 8'hFF; a fresh press therefore needs a full release first.
  - Simultaneous Ack and new D change in HOLD: Ack wins, go to RELEASE.
  - nReset asserted mid-HOLD: Valid drops immediately (asynchronous); no report is retained.
  - Counter saturates and never wraps.

Decomposition:
- Shared package encodeur_pkg:
  - LINES_INACTIVE = 8'hFF
  - state encoding IDLE/HOLD/RELEASE (2 bits)
  - function lowest_zero_index(8-bit) returning 3 bits
  - function count_gt1(8-bit)
- One sub-module: line_debouncer. It contains the synchroniser, counter and D register, parameterised by DEBOUNCE_CYCLES and WIDTH=8, with ports Clk, nReset, raw input, and debounced output.
- The top level holds the encoder and FSM.

Test Plan:
- Reset, then drive 8'hFB stable → Valid=1 at edge 7, CodedOutput=2, Multiple=0. Pulse Ack → Valid=0 next edge. Hold 8'hFB 20 more cycles → no new Valid.
- Release to 8'hFF, then drive 8'h7E → CodedOutput=0, Multiple=1. After Ack, drive 8'h7F without passing through 8'hFF → no report. Go to 8'hFF then 8'h7F → CodedOutput=7, Multiple=0.
- Drive 8'hEF for 3 cycles, then back to 8'hFF (glitch shorter than DEBOUNCE_CYCLES) → Valid never asserts. Same pattern held 4+ cycles → Valid asserts with code 4.
- Ack=1 while IDLE with lines inactive → no state change, Valid stays 0. Ack tied high during a press → Valid high for exactly one cycle.
- In HOLD with code 2, change input to 8'hFE → CodedOutput stays 2 until Ack.
- Assert nReset mid-HOLD → Valid, CodedOutput and Multiple = 0 immediately. After release with input still 8'hFD → a fresh report with code 1 after DEBOUNCE_CYCLES+3 edges.

Source files
------------

// File: rtl/encodeur_pkg.sv
// Shared definitions for the 8-to-3 synchronous priority encoder:
// idle line level, FSM state encoding and the encoding helper functions.
package encodeur_pkg;

  localparam logic [7:0] LINES_INACTIVE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Index of the lowest line driven low; 0 when no line is active.
  function automatic logic [2:0] lowest_zero_index(input logic [7:0] lines);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!lines[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // True when more than one line is driven low.
  function automatic logic count_gt1(input logic [7:0] lines);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (!lines[i]) cnt++;
    end
    return (cnt > 1);
  endfunction

endpackage

// File: rtl/line_debouncer.sv
// Two-flop synchroniser followed by a stability counter. The debounced
// vector only follows the synchronised vector once that vector has held
// the same value for DEBOUNCE_CYCLES consecutive samples.
module line_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WIDTH           = 8
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_debounced
);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("line_debouncer: DEBOUNCE_CYCLES must be within 2..255");
  end

  // The sample that first shows a new value has already cleared the
  // counter one edge earlier, so the threshold sits two below the
  // requested number of stable samples.
  localparam logic [7:0] THRESHOLD = 8'(DEBOUNCE_CYCLES - 2);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_syncPrev;
  logic [WIDTH-1:0] r_debounced;
  logic [7:0]       r_count;

  // Synchronise, measure how long the synchronised value has been stable, accept it when long enough.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_sync1     <= '1;
      r_sync2     <= '1;
      r_syncPrev  <= '1;
      r_debounced <= '1;
      r_count     <= 8'd0;
    end else begin
      r_sync1    <= i_raw;
      r_sync2    <= r_sync1;
      r_syncPrev <= r_sync2;
      if (r_sync2 != r_syncPrev) begin
        r_count <= 8'd0;
      end else begin
        if (r_count != 8'hFF) r_count <= r_count + 8'd1;
        if (r_count >= THRESHOLD) r_debounced <= r_sync2;
      end
    end
  end

  assign o_debounced = r_debounced;

endmodule

// File: rtl/encodeur_8vers3_sync.sv
// Sequential 8-to-3 priority encoder for active-low one-hot request lines.
// Lines are synchronised and debounced, the lowest active line is encoded
// and each press is reported once through a Valid/Ack handshake.
module encodeur_8vers3_sync
  import encodeur_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic [7:0] DecodedInput,
  output logic [2:0] CodedOutput,
  output logic       Valid,
  input  logic       Ack,
  output logic       Multiple
);

  logic [7:0] w_debounced;
  logic [2:0] w_code;
  logic       w_many;

  state_t     r_state;
  logic [2:0] r_code;
  logic       r_valid;
  logic       r_multiple;

  line_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .WIDTH          (8)
  ) u_debouncer (
    .Clk        (Clk),
    .nReset     (nReset),
    .i_raw      (DecodedInput),
    .o_debounced(w_debounced)
  );

  assign w_code = lowest_zero_index(w_debounced);
  assign w_many = count_gt1(w_debounced);

  // Report FSM: capture a press, hold it until acknowledged, then demand a full release before re-arming.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_state    <= IDLE;
      r_code     <= 3'd0;
      r_valid    <= 1'b0;
      r_multiple <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_debounced != LINES_INACTIVE) begin
            r_code     <= w_code;
            r_multiple <= w_many;
            r_valid    <= 1'b1;
            r_state    <= HOLD;
          end
        end
        HOLD: begin
          if (Ack) begin
            r_valid <= 1'b0;
            r_state <= RELEASE;
          end
        end
        RELEASE: begin
          if (w_debounced == LINES_INACTIVE) r_state <= IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign CodedOutput = r_code;
  assign Valid       = r_valid;
  assign Multiple    = r_multiple;

endmodule
